led_cmd_pio: RTL and testbench

- Parametrised successor of the single-register LED output PIO.
- Avalon-MM slave on the Nios II bus. Each write to the DATA register queues an LED command word, such as an LED address or colour, into an internal FIFO.
- The FIFO drains to the LED strip driver over a valid/ready stream.
- Adds status, overflow detection, flush, output enable and a popped-word counter.

---
 rtl/led_cmd_pkg.sv | 18 +
 rtl/led_cmd_fifo.sv | 72 +++++++
 rtl/led_cmd_pio.sv | 138 +++++++++++++
 tb/tb_led_cmd_pio.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_pkg.sv
// led_cmd_pkg
//   Shared constants for the LED command PIO: Avalon register word offsets,
//   STATUS read-bit positions and STATUS write-command bit positions.
package led_cmd_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;

    localparam int CMD_FLUSH   = 0;
    localparam int CMD_CLR_OVF = 1;

endpackage

// File: rtl/led_cmd_fifo.sv
// led_cmd_fifo
//   Synchronous FIFO holding LED command words.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     push, din   write request and data; accepted when not full, or when
//                 a pop happens in the same cycle (full is judged after the pop)
//     pop         read request; ignored when empty
//     flush       empties the FIFO after any same-cycle pop; storage untouched
//     dout        head word, read straight from storage
//     level       number of stored words (AW+1 bits)
//     full, empty level == DEPTH / level == 0
module led_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (level == DEPTH[AW:0]);
    assign empty = (level == '0);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            // Storage is cleared on reset so the head word is never X.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            end
        end
    end

endmodule

// File: rtl/led_cmd_pio.sv
// led_cmd_pio
//   Avalon-MM slave that queues LED command words into a FIFO and streams
//   them out over valid/ready. Adds status, sticky overflow, flush, output
//   enable and a counter of completed output handshakes.
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     address, chipselect,
//     write_n, writedata    Avalon write side
//     readdata              combinational read data (zero wait states)
//     out_data, out_valid,
//     out_ready             command stream to the LED strip driver
//   Registers: 0 DATA, 1 STATUS, 2 COUNT, 3 CTRL.
module led_cmd_pio
    import led_cmd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int AW = $clog2(DEPTH);

    logic             wr;
    logic             wr_data;
    logic             wr_status;
    logic             wr_count;
    logic             wr_ctrl;
    logic             handshake;
    logic             flush;
    logic             dropped;

    logic [WIDTH-1:0] shadow;
    logic             overflow;
    logic [31:0]      count_q;
    logic             out_en;

    logic [AW:0]      level;
    logic             full;
    logic             empty;

    logic             unused_writedata;

    assign wr        = chipselect & ~write_n;
    assign wr_data   = wr & (address == REG_DATA);
    assign wr_status = wr & (address == REG_STATUS);
    assign wr_count  = wr & (address == REG_COUNT);
    assign wr_ctrl   = wr & (address == REG_CTRL);

    assign out_valid = out_en & ~empty;
    assign handshake = out_valid & out_ready;
    assign flush     = wr_status & writedata[CMD_FLUSH];

    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign dropped   = wr_data & full & ~handshake;

    assign unused_writedata = ^writedata;

    led_cmd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (handshake),
        .flush (flush),
        .din   (writedata[WIDTH-1:0]),
        .dout  (out_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= '0;
            overflow <= 1'b0;
            count_q  <= '0;
            out_en   <= 1'b1;
        end else begin
            if (wr_data) begin
                shadow <= writedata[WIDTH-1:0];
            end

            // Set has priority over clear.
            if (dropped) begin
                overflow <= 1'b1;
            end else if (wr_status && writedata[CMD_CLR_OVF]) begin
                overflow <= 1'b0;
            end

            // Clear has priority over a same-cycle handshake increment.
            if (wr_count) begin
                count_q <= '0;
            end else if (handshake) begin
                count_q <= count_q + 32'd1;
            end

            if (wr_ctrl) begin
                out_en <= writedata[0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA: begin
                readdata[WIDTH-1:0] = shadow;
            end
            REG_STATUS: begin
                readdata[AW:0]     = level;
                readdata[ST_EMPTY] = empty;
                readdata[ST_FULL]  = full;
                readdata[ST_OVF]   = overflow;
            end
            REG_COUNT: begin
                readdata = count_q;
            end
            REG_CTRL: begin
                readdata[0] = out_en;
            end
            default: begin
                readdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_led_cmd_pio.sv
module tb_led_cmd_pio;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain queue plus the architectural registers.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_shadow;
    logic             m_ovf;
    logic [31:0]      m_cnt;
    logic             m_en;

    led_cmd_pio #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r = 32'(m_shadow);
            2'd1: begin
                r = 32'(q.size());
                r[16] = (q.size() == 0);
                r[17] = (q.size() == DEPTH);
                r[18] = m_ovf;
            end
            2'd2: r = m_cnt;
            default: r = {31'b0, m_en};
        endcase
        return r;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_shadow = '0;
        m_ovf    = 1'b0;
        m_cnt    = '0;
        m_en     = 1'b1;
    endfunction

    // Check outputs against the model, apply this cycle's effects to the
    // model, then advance one clock.
    task automatic step();
        bit mv;
        bit hs;
        #1;
        chk("readdata", readdata, exp_rd(address));
        mv = m_en && (q.size() != 0);
        chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
        if (mv) chk("out_data", 32'(out_data), 32'(q[0]));
        if (reset) begin
            model_reset();
        end else begin
            hs = mv && out_ready;
            if (hs) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: begin
                        m_shadow = writedata[WIDTH-1:0];
                        if (q.size() < DEPTH) q.push_back(writedata[WIDTH-1:0]);
                        else m_ovf = 1'b1;
                    end
                    2'd1: begin
                        if (writedata[0]) q.delete();
                        if (writedata[1]) m_ovf = 1'b0;
                    end
                    2'd2: m_cnt = '0;
                    default: m_en = writedata[0];
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        chk("reg_read", readdata, exp_rd(a));
    endtask

    task automatic rd_const(string tag, logic [1:0] a, logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        rd_const("rst_data",   2'd0, 32'h0);
        rd_const("rst_status", 2'd1, 32'h0001_0000);
        rd_const("rst_count",  2'd2, 32'h0);
        rd_const("rst_ctrl",   2'd3, 32'h1);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);

        // Two words, held head, then drain
        wr(2'd0, 32'hA5);
        chk("valid_after_first", {31'b0, out_valid}, 32'h1);
        wr(2'd0, 32'h3C);
        chk("head_held", 32'(out_data), 32'hA5);
        rd_const("level2", 2'd1, 32'h0000_0002);
        out_ready = 1'b1;
        step();
        chk("second_word", 32'(out_data), 32'h3C);
        step();
        out_ready = 1'b0;
        rd_const("count2", 2'd2, 32'h2);
        rd_const("empty_after_drain", 2'd1, 32'h0001_0000);

        // Overflow
        for (int i = 0; i <= 16; i++) wr(2'd0, 32'(i));
        rd_const("full_ovf", 2'd1, 32'h0006_0010);
        rd_const("shadow_dropped", 2'd0, 32'h10);
        out_ready = 1'b1;
        repeat (16) step();
        out_ready = 1'b0;
        rd_const("drained_ovf_sticky", 2'd1, 32'h0005_0000);
        wr(2'd1, 32'h2);
        rd_const("ovf_cleared", 2'd1, 32'h0001_0000);

        // Push and pop at full
        for (int i = 0; i < 16; i++) wr(2'd0, 32'h20 + 32'(i));
        out_ready = 1'b1;
        wr(2'd0, 32'h77);
        rd_const("full_push_pop", 2'd1, 32'h0002_0010);
        repeat (15) step();
        chk("last_word", 32'(out_data), 32'h77);
        step();
        out_ready = 1'b0;
        rd_const("empty_after_77", 2'd1, 32'h0001_0000);

        // Output disable, flush, re-enable
        for (int i = 0; i < 3; i++) wr(2'd0, 32'h40 + 32'(i));
        wr(2'd3, 32'h0);
        out_ready = 1'b1;
        repeat (10) step();
        rd_const("count_frozen", 2'd2, 32'd35);
        wr(2'd1, 32'h1);
        rd_const("flushed", 2'd1, 32'h0001_0000);
        wr(2'd3, 32'h1);
        chk("valid_after_reenable", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b0;

        // COUNT wrap
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_cnt = 32'hFFFF_FFFF;
        rd(2'd2);
        wr(2'd0, 32'h55);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        rd_const("count_wrap", 2'd2, 32'h0);

        // Reset mid-stream
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        chk("valid_before_reset", {31'b0, out_valid}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("valid_after_reset", {31'b0, out_valid}, 32'h0);
        rd_const("status_after_reset", 2'd1, 32'h0001_0000);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int op;
            op = int'($urandom_range(0, 99));
            out_ready = ($urandom_range(0, 99) < 40);
            if (op < 45) begin
                wr(2'd0, $urandom());
            end else if (op < 48) begin
                wr(2'd1, {$urandom_range(0, 1) == 0 ? 30'h0 : 30'h3FFF_FFFF,
                          $urandom_range(0, 3) == 0 ? 1'b1 : 1'b0,
                          $urandom_range(0, 4) == 0 ? 1'b1 : 1'b0});
            end else if (op < 51) begin
                wr(2'd3, {31'b0, $urandom_range(0, 3) != 0});
            end else if (op < 52) begin
                wr(2'd2, $urandom());
            end else begin
                address    = 2'($urandom_range(0, 3));
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'b1;
                writedata  = $urandom();
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
